alu_arbiter: RTL and testbench

- Shares the single 4-bit ALU between two requesters (e.g. switch/button front-end and a test sequencer).
- Each requester gets a valid/ready command channel. Results return on one shared response channel tagged with the requester id.
- Controls the ALU's operand and opcode inputs and captures its result and flags. It does not interpret opcodes.

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Optional per-requester grant counters are enabled by ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int W   = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_carry,
  output logic           rsp_zero,
  output logic           rsp_overflow,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_carry,
  input  logic           alu_zero,
  input  logic           alu_overflow
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]     grant_cnt0,
  output logic [7:0]     grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  state_t state_next;
  logic   rr_ptr;
  logic   granted_any;
  logic   cmd_id;
  logic   grant0;
  logic   grant1;
  logic   accept;

  // granted_any keeps req0 ahead until the first grant after reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (granted_any && !rr_ptr) grant1 = 1'b1;
      else                        grant0 = 1'b1;
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  assign accept = (state == IDLE) && (grant0 || grant1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = rst && (state == IDLE) && grant0;
    req1_ready = rst && (state == IDLE) && grant1;
    rsp_valid  = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      cmd_id       <= 1'b0;
      rr_ptr       <= 1'b0;
      granted_any  <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      if (accept) begin
        alu_a       <= grant1 ? req1_a  : req0_a;
        alu_b       <= grant1 ? req1_b  : req0_b;
        alu_op      <= grant1 ? req1_op : req0_op;
        cmd_id      <= grant1;
        rr_ptr      <= grant1;
        granted_any <= 1'b1;
      end
      // payload and id change together so the response is coherent
      if (state == EXEC) begin
        rsp_id       <= cmd_id;
        rsp_result   <= alu_result;
        rsp_carry    <= alu_carry;
        rsp_zero     <= alu_zero;
        rsp_overflow <= alu_overflow;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt0 <= 8'd0;
      grant_cnt1 <= 8'd0;
    end else begin
      if (accept && grant0) grant_cnt0 <= grant_cnt0 + 8'd1;
      if (accept && grant1) grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized traffic
// against a transaction-level model; ALU_ARB_STATS_EN adds counter checks.
module tb_alu_arbiter;

  localparam int W   = 4;
  localparam int OPW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [OPW-1:0] req0_op, req1_op;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_carry, rsp_zero, rsp_overflow;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [OPW-1:0] alu_op;
  logic           alu_carry, alu_zero, alu_overflow;
`ifdef ALU_ARB_STATS_EN
  logic [7:0]     grant_cnt0, grant_cnt1;
`endif

  int checks;
  int errors;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Reference ALU: {overflow, zero, carry, result}
  function automatic logic [W+2:0] alu_fn(input logic [OPW-1:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                  v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = s[W];
                  v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = ~a;
    endcase
    return {v, (r == '0), c, r};
  endfunction

  always_comb begin
    {alu_overflow, alu_zero, alu_carry, alu_result} = alu_fn(alu_op, alu_a, alu_b);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic applyStimulus(input logic v0, input logic [OPW-1:0] op0,
                               input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic v1, input logic [OPW-1:0] op1,
                               input logic [W-1:0] a1, input logic [W-1:0] b1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: one outstanding command, response visible two edges
  // after acceptance, cleared on handshake.
  int             m_age;
  int             m_last;
  bit             m_any;
  logic [OPW-1:0] m_op;
  logic [W-1:0]   m_a, m_b;
  int             m_id;
  logic [W+2:0]   m_rsp;
  int             m_rsp_id;
  int             m_cnt [2];

  task automatic checkOutput();
    int g;
    if (!rst) begin
      m_age = 0; m_last = 0; m_any = 0;
      m_op = '0; m_a = '0; m_b = '0; m_id = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_rsp_result", rsp_result, 0);
      return;
    end
    g = -1;
    if (m_age == 0) begin
      if (req0_valid && req1_valid) g = (m_any && m_last == 0) ? 1 : 0;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    chk("ready0", req0_ready, (g == 0) ? 1 : 0);
    chk("ready1", req1_ready, (g == 1) ? 1 : 0);
    chk("rsp_valid", rsp_valid, (m_age >= 2) ? 1 : 0);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", alu_op, m_op);
    if (m_age >= 2) begin
      chk("rsp_id", rsp_id, m_rsp_id);
      chk("rsp_result", rsp_result, m_rsp[W-1:0]);
      chk("rsp_carry", rsp_carry, m_rsp[W]);
      chk("rsp_zero", rsp_zero, m_rsp[W+1]);
      chk("rsp_overflow", rsp_overflow, m_rsp[W+2]);
    end
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, m_cnt[0] % 256);
    chk("grant_cnt1", grant_cnt1, m_cnt[1] % 256);
`endif
    if (g >= 0) begin
      m_op  = (g == 1) ? req1_op : req0_op;
      m_a   = (g == 1) ? req1_a  : req0_a;
      m_b   = (g == 1) ? req1_b  : req0_b;
      m_id  = g;
      m_last = g;
      m_any = 1;
      m_cnt[g]++;
      m_age = 1;
    end else if (m_age == 1) begin
      m_rsp    = alu_fn(m_op, m_a, m_b);
      m_rsp_id = m_id;
      m_age    = 2;
    end else if (m_age >= 2 && rsp_ready) begin
      m_age = 0;
    end
  endtask

  always @(negedge clk) checkOutput();

  logic           v0, v1;
  logic [OPW-1:0] o0, o1;
  logic [W-1:0]   a0, b0, a1, b1;

  initial begin
    int order [6];
    int exp_order [6];
    int n;
    logic r0, r1;
    exp_order = '{0, 1, 0, 1, 0, 1};
    checks = 0;
    errors = 0;
    rst = 1'b0;
    rsp_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_carry", rsp_carry, 0);
    chk("reset_rsp_zero", rsp_zero, 0);
    chk("reset_alu_a", alu_a, 0);

    // Single request: 3 + 4
    tick();
    rsp_ready = 1'b1;
    applyStimulus(1, 3'b000, 3, 4, 0, 0, 0, 0);
    @(negedge clk);
    chk("single_ready0", req0_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("single_exec_ready0", req0_ready, 0);
    chk("single_exec_valid", rsp_valid, 0);
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 0);
    chk("single_result", rsp_result, 7);
    chk("single_carry", rsp_carry, 0);
    chk("single_zero", rsp_zero, 0);
    @(negedge clk);
    chk("single_back_idle", rsp_valid, 0);

    // Simultaneous requests right after reset
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    applyStimulus(1, 3'b000, 1, 1, 1, 3'b000, 2, 2);
    @(negedge clk);
    chk("simul_ready0", req0_ready, 1);
    chk("simul_ready1", req1_ready, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 3'b000, 2, 2);
    @(negedge clk);
    chk("simul_exec_ready1", req1_ready, 0);
    @(negedge clk);
    chk("simul_resp_ready1", req1_ready, 0);
    chk("simul_first_id", rsp_id, 0);
    chk("simul_first_result", rsp_result, 2);
    @(negedge clk);
    chk("simul_ready1_later", req1_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("simul_second_valid", rsp_valid, 1);
    chk("simul_second_id", rsp_id, 1);
    chk("simul_second_result", rsp_result, 4);
    repeat (2) tick();

    // Round-robin fairness with both requesters always valid
    applyStimulus(1, 3'b000, 5, 6, 1, 3'b000, 7, 8);
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      @(negedge clk);
      if (req0_ready)      begin order[n] = 0; n++; end
      else if (req1_ready) begin order[n] = 1; n++; end
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    if (n < 6) timeout_fail("fairness_grants");
    else for (int i = 0; i < 6; i++) chk("fairness_order", order[i], exp_order[i]);
    repeat (4) tick();

    // Backpressure: 15 + 1 wraps to zero with carry
    rsp_ready = 1'b0;
    applyStimulus(1, 3'b000, 15, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_ready0", req0_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 3'b000, 9, 9);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_held", rsp_valid, 1);
      chk("bp_result", rsp_result, 0);
      chk("bp_carry", rsp_carry, 1);
      chk("bp_zero", rsp_zero, 1);
      chk("bp_no_ready0", req0_ready, 0);
      chk("bp_no_ready1", req1_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_last_valid", rsp_valid, 1);
    @(negedge clk);
    chk("bp_done", rsp_valid, 0);
    tick();

    // Reset while a req1 command is executing
    applyStimulus(0, 0, 0, 0, 1, 3'b010, 3, 3);
    @(negedge clk);
    chk("mid_ready1", req1_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_no_response", rsp_valid, 0);
    end
    tick();
    applyStimulus(1, 3'b000, 1, 2, 1, 3'b000, 3, 4);
    @(negedge clk);
    chk("mid_regrant_ready0", req0_ready, 1);
    chk("mid_regrant_ready1", req1_ready, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // Randomized traffic checked by the model every cycle
    v0 = 0; v1 = 0; o0 = 0; o1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      r0 = req0_ready;
      r1 = req1_ready;
      tick();
      if (!v0 || r0) begin
        v0 = ($urandom_range(3) != 0);
        o0 = OPW'($urandom_range(7)); a0 = W'($urandom); b0 = W'($urandom);
      end else if ($urandom_range(15) == 0) v0 = 0;
      if (!v1 || r1) begin
        v1 = ($urandom_range(3) != 0);
        o1 = OPW'($urandom_range(7)); a1 = W'($urandom); b1 = W'($urandom);
      end else if ($urandom_range(15) == 0) v1 = 0;
      rsp_ready = ($urandom_range(2) != 0);
      applyStimulus(v0, o0, a0, b0, v1, o1, a1, b1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rsp_ready = 1'b1;
    repeat (4) tick();

`ifdef ALU_ARB_STATS_EN
    // 258 req1-only commands wrap its counter to 2
    rst = 1'b0;
    tick();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 3'b000, 1, 1);
    n = 0;
    for (int cyc = 0; cyc < 2000 && n < 258; cyc++) begin
      @(negedge clk);
      if (req1_ready) n++;
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    if (n < 258) timeout_fail("stats_grants");
    chk("stats_cnt1", grant_cnt1, 2);
    chk("stats_cnt0", grant_cnt0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
